// File: rtl/propose_corner_point_seq.sv
// Sequential corner-point proposer: scans a clause store, derives lower/upper bounds
// on one chosen variable and proposes a saturated value from them.
module propose_corner_point_seq #(
    parameter int unsigned MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = 8,
    parameter int unsigned MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 2,
    parameter int unsigned MAX_BIT_WIDTH_OF_INTEGER_VARIABLE   = 8,
    parameter int unsigned MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = 3,
    localparam int unsigned CW  = MAXIMUM_BIT_WIDTH_OF_COEFFICIENT,
    localparam int unsigned VIW = MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX,
    localparam int unsigned VW  = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE,
    localparam int unsigned CIW = MAX_BIT_WIDTH_OF_CLAUSES_INDEX,
    localparam int unsigned NV  = 1 << VIW,
    localparam int unsigned NC  = 1 << CIW
) (
    input  logic                        in_clk,
    input  logic                        in_reset,
    input  logic                        in_clause_write,
    input  logic [CIW-1:0]              in_clause_index,
    input  logic [(NV+1)*CW-1:0]        in_clause_coefficients,
    input  logic [CIW:0]                in_number_of_clauses,
    input  logic [NC-1:0]               in_reduce_enable,
    input  logic [NV*VW-1:0]            in_assignment_before_move,
    input  logic [VIW-1:0]              in_variable_to_be_unchanced_index,
    input  logic [1:0]                  in_mode,
    input  logic                        in_random_bit,
    input  logic                        in_start,
    input  logic                        out_ready,
    output logic                        out_busy,
    output logic                        out_valid,
    output logic signed [VW-1:0]        new_assignmet_for_the_choosen_variable,
    output logic                        out_no_corner,
    output logic                        out_infeasible,
    output logic                        out_error
);
    localparam int unsigned PW = CW + VW + VIW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_UP   = 2'd1;
    localparam logic [1:0] K_LO   = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    localparam logic signed [CW-1:0] A_POS = CW'(1);
    localparam logic signed [CW-1:0] A_NEG = {CW{1'b1}};
    localparam logic signed [PW:0]   VMAX  = (PW+1)'((2 ** (VW - 1)) - 1);
    localparam logic signed [PW:0]   VMIN  = (PW+1)'(-(2 ** (VW - 1)));

    logic [1:0]              state, state_next;
    logic [CIW-1:0]          scan_idx;
    logic                    drain_cnt;
    logic [NV*VW-1:0]        x_q;
    logic [VIW-1:0]          v_q;
    logic [1:0]              mode_q;
    logic                    rnd_q;
    logic [CIW:0]            n_q;
    logic [NC-1:0]           mask_q;
    logic [(NV+1)*CW-1:0]    store [NC];
    logic [CIW:0]            n_eff;

    logic [(NV+1)*CW-1:0]    clause;
    logic signed [CW-1:0]    a_v;
    logic signed [PW-1:0]    c_sum, bound_c;
    logic [1:0]              kind;

    logic                    s1_valid;
    logic [1:0]              s1_kind;
    logic signed [PW-1:0]    s1_bound;
    logic signed [PW-1:0]    lo_q, hi_q;
    logic                    lo_ex, hi_ex;

    logic signed [PW:0]      lh_sum, sel;
    logic                    upper_first, sel_nc, sel_inf;
    logic signed [VW-1:0]    sel_sat, x_v;

    // Requests beyond the store depth scan the whole store.
    assign n_eff = (in_number_of_clauses > (CIW+1)'(NC)) ? (CIW+1)'(NC) : in_number_of_clauses;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_start) state_next = (n_eff == '0) ? S_DRAIN : S_SCAN;
            S_SCAN:  if ({1'b0, scan_idx} == n_q - (CIW+1)'(1)) state_next = S_DRAIN;
            S_DRAIN: if (drain_cnt) state_next = S_DONE;
            S_DONE:  if (out_valid && out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Residual c of the current clause and its bound classification.
    always_comb begin
        clause  = store[scan_idx];
        a_v     = clause[32'(v_q)*CW +: CW];
        c_sum   = PW'($signed(clause[NV*CW +: CW]));
        for (int k = 0; k < NV; k++) begin
            if (k != int'(v_q))
                c_sum = c_sum + PW'($signed(clause[k*CW +: CW])) * PW'($signed(x_q[k*VW +: VW]));
        end
        kind    = K_NONE;
        bound_c = c_sum;
        if (mask_q[scan_idx] && a_v != '0) begin
            if (a_v == A_POS) begin
                kind    = K_UP;
                bound_c = -c_sum;
            end else if (a_v == A_NEG) begin
                kind    = K_LO;
            end else begin
                kind    = K_ERR;
            end
        end
    end

    // Corner selection from the accumulated bounds, then saturation to VW.
    always_comb begin
        sel         = '0;
        sel_nc      = 1'b0;
        lh_sum      = (PW+1)'(lo_q) + (PW+1)'(hi_q);
        upper_first = (mode_q == 2'd1) || (mode_q == 2'd2 && rnd_q);
        x_v         = x_q[32'(v_q)*VW +: VW];
        sel_inf     = lo_ex && hi_ex && (lo_q > hi_q);
        if (!lo_ex && !hi_ex) begin
            sel    = (PW+1)'(x_v);
            sel_nc = 1'b1;
        end else if (lo_ex && hi_ex) begin
            if (mode_q == 2'd3) sel = lh_sum >>> 1;
            else                sel = upper_first ? (PW+1)'(hi_q) : (PW+1)'(lo_q);
        end else begin
            sel = lo_ex ? (PW+1)'(lo_q) : (PW+1)'(hi_q);
        end
        sel_sat = VW'(sel);
        if (sel > VMAX)      sel_sat = VW'(VMAX);
        else if (sel < VMIN) sel_sat = VW'(VMIN);
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state          <= S_IDLE;
            scan_idx       <= '0;
            drain_cnt      <= 1'b0;
            x_q            <= '0;
            v_q            <= '0;
            mode_q         <= '0;
            rnd_q          <= 1'b0;
            n_q            <= '0;
            mask_q         <= '0;
            s1_valid       <= 1'b0;
            s1_kind        <= K_NONE;
            s1_bound       <= '0;
            lo_q           <= '0;
            hi_q           <= '0;
            lo_ex          <= 1'b0;
            hi_ex          <= 1'b0;
            out_busy       <= 1'b0;
            out_valid      <= 1'b0;
            out_no_corner  <= 1'b0;
            out_infeasible <= 1'b0;
            out_error      <= 1'b0;
            new_assignmet_for_the_choosen_variable <= '0;
            for (int i = 0; i < NC; i++) store[i] <= '0;
        end else begin
            state    <= state_next;
            out_busy <= (state_next != S_IDLE);

            if (state == S_IDLE && in_clause_write)
                store[in_clause_index] <= in_clause_coefficients;

            if (state == S_IDLE && in_start) begin
                x_q       <= in_assignment_before_move;
                v_q       <= in_variable_to_be_unchanced_index;
                mode_q    <= in_mode;
                rnd_q     <= in_random_bit;
                n_q       <= n_eff;
                mask_q    <= in_reduce_enable;
                scan_idx  <= '0;
                drain_cnt <= 1'b0;
                lo_q      <= '0;
                hi_q      <= '0;
                lo_ex     <= 1'b0;
                hi_ex     <= 1'b0;
            end

            if (state == S_SCAN)  scan_idx  <= scan_idx + CIW'(1);
            if (state == S_DRAIN) drain_cnt <= ~drain_cnt;

            s1_valid <= (state == S_SCAN);
            s1_kind  <= kind;
            s1_bound <= bound_c;

            if (s1_valid) begin
                if (s1_kind == K_UP && (!hi_ex || s1_bound < hi_q)) begin
                    hi_q  <= s1_bound;
                    hi_ex <= 1'b1;
                end
                if (s1_kind == K_LO && (!lo_ex || s1_bound > lo_q)) begin
                    lo_q  <= s1_bound;
                    lo_ex <= 1'b1;
                end
                if (s1_kind == K_ERR) out_error <= 1'b1;
            end

            // Result is captured once on the first DONE cycle and held until accepted.
            if (state == S_DONE && !out_valid) begin
                out_valid      <= 1'b1;
                out_no_corner  <= sel_nc;
                out_infeasible <= sel_inf;
                new_assignmet_for_the_choosen_variable <= sel_sat;
            end else if (state == S_DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_propose_corner_point_seq.sv
// Scoreboard bench for propose_corner_point_seq: directed runs push expectations,
// a negedge monitor checks each presented result, its latency and its stability.
module tb_propose_corner_point_seq;
    logic              in_clk = 1'b0;
    logic              in_reset;
    logic              in_clause_write;
    logic [2:0]        in_clause_index;
    logic [39:0]       in_clause_coefficients;
    logic [3:0]        in_number_of_clauses;
    logic [7:0]        in_reduce_enable;
    logic [31:0]       in_assignment_before_move;
    logic [1:0]        in_variable_to_be_unchanced_index;
    logic [1:0]        in_mode;
    logic              in_random_bit;
    logic              in_start;
    logic              out_ready;
    logic              out_busy;
    logic              out_valid;
    logic signed [7:0] new_assignmet_for_the_choosen_variable;
    logic              out_no_corner;
    logic              out_infeasible;
    logic              out_error;

    propose_corner_point_seq dut (
        .in_clk                                 (in_clk),
        .in_reset                               (in_reset),
        .in_clause_write                        (in_clause_write),
        .in_clause_index                        (in_clause_index),
        .in_clause_coefficients                 (in_clause_coefficients),
        .in_number_of_clauses                   (in_number_of_clauses),
        .in_reduce_enable                       (in_reduce_enable),
        .in_assignment_before_move              (in_assignment_before_move),
        .in_variable_to_be_unchanced_index      (in_variable_to_be_unchanced_index),
        .in_mode                                (in_mode),
        .in_random_bit                          (in_random_bit),
        .in_start                               (in_start),
        .out_ready                              (out_ready),
        .out_busy                               (out_busy),
        .out_valid                              (out_valid),
        .new_assignmet_for_the_choosen_variable (new_assignmet_for_the_choosen_variable),
        .out_no_corner                          (out_no_corner),
        .out_infeasible                         (out_infeasible),
        .out_error                              (out_error)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        int value;
        int nc;
        int inf;
        int err;
        int exp_cyc;
        int id;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   prev_valid = 1'b0;

    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare on valid rise, then check held outputs against the same expectation.
    always @(negedge in_clk) begin
        if (in_reset) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    cur = q.pop_front();
                    chk($sformatf("r%0d_latency", cur.id), cyc, cur.exp_cyc);
                    chk($sformatf("r%0d_value", cur.id), int'(new_assignmet_for_the_choosen_variable), cur.value);
                    chk($sformatf("r%0d_no_corner", cur.id), int'(out_no_corner), cur.nc);
                    chk($sformatf("r%0d_infeasible", cur.id), int'(out_infeasible), cur.inf);
                    chk($sformatf("r%0d_error", cur.id), int'(out_error), cur.err);
                end
            end else if (out_valid) begin
                chk($sformatf("r%0d_hold_value", cur.id), int'(new_assignmet_for_the_choosen_variable), cur.value);
                chk($sformatf("r%0d_hold_no_corner", cur.id), int'(out_no_corner), cur.nc);
                chk($sformatf("r%0d_hold_infeasible", cur.id), int'(out_infeasible), cur.inf);
            end
            prev_valid = out_valid;
        end
    end

    task automatic wr(input int idx, input int a0, input int a1, input int a2, input int a3, input int b);
        @(negedge in_clk);
        in_clause_write        = 1'b1;
        in_clause_index        = 3'(idx);
        in_clause_coefficients = {8'(b), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        @(negedge in_clk);
        in_clause_write        = 1'b0;
    endtask

    task automatic run(input int id, input int x0, input int x1, input int v, input int mode,
                       input int rnd, input int n, input int mask,
                       input int ev, input int enc, input int einf, input int eerr);
        exp_t e;
        @(negedge in_clk);
        in_assignment_before_move         = {8'd0, 8'd0, 8'(x1), 8'(x0)};
        in_variable_to_be_unchanced_index = 2'(v);
        in_mode                           = 2'(mode);
        in_random_bit                     = 1'(rnd);
        in_number_of_clauses              = 4'(n);
        in_reduce_enable                  = 8'(mask);
        in_start                          = 1'b1;
        @(negedge in_clk);
        in_start  = 1'b0;
        e.value   = ev;
        e.nc      = enc;
        e.inf     = einf;
        e.err     = eerr;
        e.exp_cyc = cyc + n + 3;
        e.id      = id;
        q.push_back(e);
    endtask

    task automatic wait_done(input int id);
        for (int i = 0; i < 100; i++) begin
            @(negedge in_clk);
            if (q.size() == 0 && !out_valid) return;
        end
        chk($sformatf("r%0d_timeout", id), 1, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(out_busy), 0);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_value"}, int'(new_assignmet_for_the_choosen_variable), 0);
        chk({tag, "_no_corner"}, int'(out_no_corner), 0);
        chk({tag, "_infeasible"}, int'(out_infeasible), 0);
        chk({tag, "_error"}, int'(out_error), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        in_reset = 1'b1;
        in_clause_write = 1'b0;
        in_clause_index = '0;
        in_clause_coefficients = '0;
        in_number_of_clauses = '0;
        in_reduce_enable = '0;
        in_assignment_before_move = '0;
        in_variable_to_be_unchanced_index = '0;
        in_mode = '0;
        in_random_bit = 1'b0;
        in_start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge in_clk);
        in_reset = 1'b0;
        @(negedge in_clk);
        chk_all_zero("reset");

        // Two bounds on x0: upper 6, lower 3.
        wr(0, 1, 2, 0, 0, -10);
        wr(1, -1, 1, 0, 0, 1);
        run(1, 3, 2, 0, 0, 0, 2, 'hFF, 3, 0, 0, 0);  wait_done(1);
        run(2, 3, 2, 0, 1, 0, 2, 'hFF, 6, 0, 0, 0);  wait_done(2);
        run(3, 3, 2, 0, 3, 0, 2, 'hFF, 4, 0, 0, 0);  wait_done(3);
        run(4, 3, 2, 0, 2, 0, 2, 'hFF, 3, 0, 0, 0);  wait_done(4);
        run(5, 3, 2, 0, 2, 1, 2, 'hFF, 6, 0, 0, 0);  wait_done(5);

        // lo=7 > hi=6.
        wr(1, -1, 1, 0, 0, 5);
        run(6, 3, 2, 0, 0, 0, 2, 'hFF, 7, 0, 1, 0);  wait_done(6);

        // No active bound.
        run(7, 3, 2, 0, 0, 0, 0, 'hFF, 3, 1, 0, 0);  wait_done(7);
        run(8, 3, 2, 0, 0, 0, 2, 'h00, 3, 1, 0, 0);  wait_done(8);

        // Illegal coefficient on the chosen variable; error is sticky.
        wr(1, 2, 0, 0, 0, 0);
        run(9, 3, 2, 0, 0, 0, 2, 'hFF, 6, 0, 0, 1);  wait_done(9);
        wr(1, -1, 1, 0, 0, 1);
        run(10, 3, 2, 0, 0, 0, 2, 'hFF, 3, 0, 0, 1); wait_done(10);

        // Reset in the middle of a scan.
        @(negedge in_clk);
        in_number_of_clauses = 4'd2;
        in_reduce_enable     = 8'hFF;
        in_mode              = 2'd0;
        in_start             = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        in_reset = 1'b1;
        @(negedge in_clk);
        chk_all_zero("midscan_reset");
        in_reset = 1'b0;
        run(11, 3, 2, 0, 0, 0, 2, 'hFF, 3, 1, 0, 0); wait_done(11);

        // Saturation high with a stalled consumer; start and clause write while stalled are ignored.
        wr(0, -1, 127, 0, 0, 127);
        out_ready = 1'b0;
        run(12, 3, 2, 0, 0, 0, 1, 'hFF, 127, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge in_clk);
            if (out_valid) seen = 1'b1;
        end
        chk("r12_valid_seen", int'(seen), 1);
        @(negedge in_clk);
        in_start = 1'b1;
        @(negedge in_clk);
        in_start               = 1'b0;
        in_clause_write        = 1'b1;
        in_clause_index        = 3'd0;
        in_clause_coefficients = {8'd100, 8'd0, 8'd0, 8'd0, 8'd1};
        @(negedge in_clk);
        in_clause_write = 1'b0;
        @(negedge in_clk);
        chk("r12_valid_held", int'(out_valid), 1);
        chk("r12_busy_held", int'(out_busy), 1);
        out_ready = 1'b1;
        @(negedge in_clk);
        chk("r12_valid_dropped", int'(out_valid), 0);
        chk("r12_busy_dropped", int'(out_busy), 0);
        repeat (10) @(negedge in_clk);
        chk("r12_start_ignored", int'(out_busy), 0);
        run(13, 3, 2, 0, 0, 0, 1, 'hFF, 127, 0, 0, 0); wait_done(13);

        // Saturation low: only an upper bound of -381, midpoint mode falls back to it.
        wr(0, 1, 127, 0, 0, 127);
        run(14, 3, 2, 0, 3, 0, 1, 'hFF, -128, 0, 0, 0); wait_done(14);

        repeat (3) @(negedge in_clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/propose_corner_point_seq.md
PROPOSE_CORNER_POINT_SEQ -- requirements
Module: propose_corner_point_seq

Interface
REQ-001 SHALL have parameter MAXIMUM_BIT_WIDTH_OF_COEFFICIENT, default 8, meaning signed coefficient/bias width (CW).
REQ-002 SHALL have parameter MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX, default 2, meaning NV = 2**value variables.
REQ-003 SHALL have parameter MAX_BIT_WIDTH_OF_INTEGER_VARIABLE, default 8, meaning signed variable width (VW); VW and CW are independent.
REQ-004 SHALL have parameter MAX_BIT_WIDTH_OF_CLAUSES_INDEX, default 3, meaning clause store depth NC = 2**value.
REQ-005 SHALL have the ports below; one clock, reset synchronous active-high:
- in_clk  in  1  clock
- in_reset  in  1  synchronous active-high reset
- in_clause_write  in  1  write strobe into the clause store
- in_clause_index  in  MAX_BIT_WIDTH_OF_CLAUSES_INDEX  write address
- in_clause_coefficients  in  (NV+1)*CW  slot k = variable k coefficient, slot NV = bias b
- in_number_of_clauses  in  MAX_BIT_WIDTH_OF_CLAUSES_INDEX+1  N, clauses scanned (0..NC)
- in_reduce_enable  in  NC  per-clause enable mask
- in_assignment_before_move  in  NV*VW  current x, slot k = x_k
- in_variable_to_be_unchanced_index  in  MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX  chosen variable v
- in_mode  in  2  0 lower-first, 1 upper-first, 2 random, 3 midpoint
- in_random_bit  in  1  random choice for mode 2
- in_start  in  1  start request
- out_ready  in  1  consumer accepts result
- out_busy  out  1  high in every state except IDLE
- out_valid  out  1  result valid
- new_assignmet_for_the_choosen_variable  out  VW signed  proposed value
- out_no_corner  out  1  no active bound found
- out_infeasible  out  1  lower bound > upper bound
- out_error  out  1  sticky: illegal chosen-variable coefficient seen

Function
REQ-006 SHALL store a clause on in_clause_write only in IDLE; writes in other states SHALL be ignored.
REQ-007 SHALL accept in_start only in IDLE, latching x, v, mode, random bit, N and mask; in_start otherwise ignored.
REQ-008 FSM SHALL be IDLE -> SCAN (N cycles, one clause per cycle, index 0..N-1) -> DRAIN (2 cycles) -> DONE -> IDLE; N=0 goes IDLE -> DRAIN.
REQ-009 out_valid SHALL rise exactly N+3 cycles after the accepting edge and SHALL hold, with all result outputs stable, until a cycle with out_ready=1; DONE then returns to IDLE.
REQ-010 Per clause: c = b + sum over k!=v of a_k*x_k, full precision (CW+VW+MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX+1 bits, no overflow); clause meaning a_v*y + c <= 0.
REQ-011 a_v=+1 SHALL contribute upper bound -c; a_v=-1 SHALL contribute lower bound c; a_v=0 or mask bit 0 SHALL contribute nothing.
REQ-012 Any other a_v on an enabled clause SHALL contribute nothing and SHALL set out_error (cleared only by reset).
REQ-013 SHALL track lo = max of lower bounds and hi = min of upper bounds, each with an exists flag, all cleared at start acceptance.
REQ-014 Selection: mode 0 lo if it exists else hi; mode 1 hi else lo; mode 2 random=0 as mode 0, random=1 as mode 1; mode 3 floor((lo+hi)/2) if both exist, else whichever exists.
REQ-015 Neither bound exists: out_no_corner=1 and output = latched x_v.
REQ-016 out_infeasible=1 iff both exist and lo > hi; the selected value is still output.
REQ-017 The selected value SHALL saturate to the signed VW range.

Reset
REQ-018 in_reset SHALL, at any state including mid-scan, force IDLE, zero all outputs including out_error, zero the clause store, and discard any run.

Verification
REQ-019 Defaults; x=(3,2,0,0), v=0; clause0 a=(+1,2,0,0) b=-10; clause1 a=(-1,1,0,0) b=1; N=2, mask=0xFF, mode 0 -> out_valid at T+5, value 3; mode 1 -> 6; mode 3 -> 4; infeasible=0.
REQ-020 clause1 bias changed to 5 (lo=7, hi=6), mode 0 -> value 7, out_infeasible=1.
REQ-021 N=0, x_v=3 -> out_valid at T+3, out_no_corner=1, value 3; same result with N=2 and mask=0x00.
REQ-022 Clause with a_v=2 plus clause0 above -> out_error=1, value 6 in mode 0; out_error stays 1 across a new run until reset.
REQ-023 a=(-1,127,0,0), b=127, x1=2 (c=381) -> value saturates to 127; out_ready held 0 for 5 cycles -> outputs stable, and a start pulse in that window is ignored.
REQ-024 Reset asserted during SCAN -> next cycle out_busy=0, out_valid=0, all outputs 0; rerun with clause store empty -> out_no_corner=1.
